// File: rtl/range_expander.sv
// Expands inclusive [lo, hi] ranges into beats of LANES consecutive values plus a per-lane keep mask.
// Define RANGE_EXPANDER_STATS_EN to add the stat_ranges / stat_values counters.
module range_expander #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned LANES     = 4,
  parameter type         DATA_TYPE = logic [BIT_WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  DATA_TYPE         in_lo,
  input  DATA_TYPE         in_hi,
  output logic             in_ready,
  output logic             out_valid,
  output DATA_TYPE         out_data [0:LANES-1],
  output logic [LANES-1:0] out_keep,
  input  logic             out_ready,
  output logic             busy
`ifdef RANGE_EXPANDER_STATS_EN
  ,
  output logic [31:0]      stat_ranges,
  output logic [63:0]      stat_values
`endif
);

  typedef logic [BIT_WIDTH-1:0] word_t;
  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;
  word_t  cur_q, cur_d;
  word_t  hi_q, hi_d;
  word_t  lo_in, hi_in, span;
  logic   emitting, last, xfer, accept, non_empty;

  // span never underflows because hi_q >= cur_q whenever a beat is shown
  always_comb begin
    lo_in     = word_t'(in_lo);
    hi_in     = word_t'(in_hi);
    span      = hi_q - cur_q;
    emitting  = (state_q == EMIT);
    last      = span < word_t'(LANES);
    xfer      = emitting && out_ready;
    in_ready  = !rst && (!emitting || (last && out_ready));
    accept    = in_valid && in_ready;
    non_empty = lo_in <= hi_in;

    state_d = state_q;
    cur_d   = cur_q;
    hi_d    = hi_q;
    if (xfer) begin
      if (last) state_d = IDLE;
      else      cur_d   = cur_q + word_t'(LANES);
    end
    if (accept) begin
      state_d = non_empty ? EMIT : IDLE;
      if (non_empty) begin
        cur_d = lo_in;
        hi_d  = hi_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hi_q    <= hi_d;
    end
  end

  assign out_valid = emitting;
  assign busy      = emitting;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign out_data[i] = DATA_TYPE'(emitting ? cur_q + word_t'(i) : word_t'(0));
    assign out_keep[i] = emitting && (word_t'(i) <= span);
  end

`ifdef RANGE_EXPANDER_STATS_EN
  logic [31:0] stat_ranges_q, stat_ranges_d;
  logic [63:0] stat_values_q, stat_values_d;
  logic [63:0] kept;

  always_comb begin
    kept = '0;
    for (int k = 0; k < LANES; k++) kept = kept + 64'(out_keep[k]);
    stat_ranges_d = stat_ranges_q + 32'(accept && non_empty);
    stat_values_d = xfer ? stat_values_q + kept : stat_values_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ranges_q <= '0;
      stat_values_q <= '0;
    end else begin
      stat_ranges_q <= stat_ranges_d;
      stat_values_q <= stat_values_d;
    end
  end

  assign stat_ranges = stat_ranges_q;
  assign stat_values = stat_values_q;
`endif

endmodule

// File: tb/tb_range_expander.sv
// Self-checking bench for range_expander: table of ranges plus hand-written corner sequences,
// with a beat scoreboard filled on range acceptance and drained on each beat transfer.
module tb_range_expander;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_lo = '0;
  logic [31:0] in_hi = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data [0:3];
  logic [3:0]  out_keep;
  logic        out_ready = 1'b0;
  logic        busy;
`ifdef RANGE_EXPANDER_STATS_EN
  logic [31:0] stat_ranges;
  logic [63:0] stat_values;
`endif

  range_expander #(.BIT_WIDTH(32), .LANES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_lo(in_lo), .in_hi(in_hi), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_ready(out_ready), .busy(busy)
`ifdef RANGE_EXPANDER_STATS_EN
    , .stat_ranges(stat_ranges), .stat_values(stat_values)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
  } beat_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          beats;
    logic [3:0]  last_keep;
  } vec_t;

  beat_t       sb[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  int          beat_count = 0;
  logic [3:0]  last_keep = '0;
  logic [63:0] exp_ranges = '0;
  logic [63:0] exp_values = '0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference beats built value by value at 33 bits, so wrap past 2^32-1 is explicit
  task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
    beat_t       e;
    logic [32:0] v;
    for (logic [32:0] b = {1'b0, lo}; b <= {1'b0, hi}; b += 33'd4) begin
      for (int i = 0; i < 4; i++) begin
        v = b + 33'(i);
        e.data[32*i +: 32] = v[31:0];
        e.keep[i] = (v <= {1'b0, hi});
      end
      sb.push_back(e);
    end
    exp_ranges++;
  endtask

  task automatic compare_beat();
    beat_t        e;
    logic [127:0] act;
    for (int i = 0; i < 4; i++) act[32*i +: 32] = out_data[i];
    beat_count++;
    last_keep = out_keep;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_beat: actual data=%0h keep=%b, required no beat", act, out_keep);
    end else begin
      e = sb.pop_front();
      check_output("beat_data", act, e.data);
      check_output("beat_keep", 128'(out_keep), 128'(e.keep));
      exp_values += 64'($countones(e.keep));
    end
  endtask

  // One cycle: drive at the falling edge, observe handshakes just after
  task automatic apply_stimulus(input logic r, input logic vld, input logic [31:0] lo,
                                input logic [31:0] hi, input logic ordy,
                                output logic acc, output logic beat);
    @(negedge clk);
    rst = r;
    in_valid = vld;
    in_lo = lo;
    in_hi = hi;
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    beat = out_valid && out_ready;
    if (acc && lo <= hi) push_range(lo, hi);
    if (beat) compare_beat();
    else if (!out_valid) begin
      for (int i = 0; i < 4; i++) check_output("idle_data_zero", 128'(out_data[i]), 128'(0));
      check_output("idle_keep_zero", 128'(out_keep), 128'(0));
    end
  endtask

  task automatic check_stats();
`ifdef RANGE_EXPANDER_STATS_EN
    check_output("stat_ranges", 128'(stat_ranges), 128'(exp_ranges[31:0]));
    check_output("stat_values", 128'(stat_values), 128'(exp_values));
`endif
  endtask

  task automatic drain();
    logic a, b;
    for (int n = 0; n < 200 && sb.size() > 0; n++) apply_stimulus(0, 0, 0, 0, 1, a, b);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: actual %0d beats outstanding, required 0", sb.size());
      sb.delete();
    end
    apply_stimulus(0, 0, 0, 0, 1, a, b);
    check_output("no_extra_beat", 128'(out_valid), 128'(0));
  endtask

  task automatic accept_range(input logic [31:0] lo, input logic [31:0] hi);
    logic a, b;
    a = 1'b0;
    for (int n = 0; n < 10 && !a; n++) apply_stimulus(0, 1, lo, hi, 1, a, b);
    check_output("range_accepted", 128'(a), 128'(1));
  endtask

  initial begin
    logic a, b;
    #2_000_000;
    $display("[TB] FAIL global_timeout: actual simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic a, b;
    vecs[0] = '{32'd10,        32'd15,        2, 4'b0011};
    vecs[1] = '{32'd7,         32'd7,         1, 4'b0001};
    vecs[2] = '{32'd9,         32'd8,         0, 4'b0000};
    vecs[3] = '{32'hFFFFFFFE,  32'hFFFFFFFF,  1, 4'b0011};
    vecs[4] = '{32'd0,         32'd11,        3, 4'b1111};
    vecs[5] = '{32'd100,       32'd103,       1, 4'b1111};
    vecs[6] = '{32'd5,         32'd6,         1, 4'b0011};
    vecs[7] = '{32'hFFFFFFF0,  32'hFFFFFFFF,  4, 4'b1111};
    vecs[8] = '{32'hFFFFFFFD,  32'hFFFFFFFF,  1, 4'b0111};

    for (int n = 0; n < 3; n++) begin
      apply_stimulus(1, 1, 32'd1, 32'd2, 0, a, b);
      check_output("reset_in_ready", 128'(in_ready), 128'(0));
      check_output("reset_out_valid", 128'(out_valid), 128'(0));
      check_output("reset_busy", 128'(busy), 128'(0));
    end
    apply_stimulus(0, 0, 0, 0, 1, a, b);
    check_output("post_reset_in_ready", 128'(in_ready), 128'(1));
    check_stats();

    for (int v = 0; v < 9; v++) begin
      beat_count = 0;
      accept_range(vecs[v].lo, vecs[v].hi);
      drain();
      check_output("beat_count", 128'(beat_count), 128'(vecs[v].beats));
      if (vecs[v].beats > 0) check_output("last_keep", 128'(last_keep), 128'(vecs[v].last_keep));
      check_stats();
    end

    // Backpressure on the second beat of [0,11]
    beat_count = 0;
    accept_range(32'd0, 32'd11);
    apply_stimulus(0, 0, 0, 0, 1, a, b);
    check_output("bp_first_beat", 128'(b), 128'(1));
    for (int n = 0; n < 3; n++) begin
      apply_stimulus(0, 0, 0, 0, 0, a, b);
      check_output("bp_valid_held", 128'(out_valid), 128'(1));
      check_output("bp_busy", 128'(busy), 128'(1));
      check_output("bp_in_ready", 128'(in_ready), 128'(0));
      check_output("bp_data_held",
                   {out_data[3], out_data[2], out_data[1], out_data[0]},
                   {32'd7, 32'd6, 32'd5, 32'd4});
      check_output("bp_keep_held", 128'(out_keep), 128'(4'b1111));
    end
    drain();
    check_output("bp_beat_count", 128'(beat_count), 128'(3));

    // Zero-bubble chaining of [0,3] into [4,7]
    apply_stimulus(0, 1, 32'd0, 32'd3, 1, a, b);
    check_output("chain_first_accept", 128'(a), 128'(1));
    apply_stimulus(0, 1, 32'd4, 32'd7, 1, a, b);
    check_output("chain_accept_with_beat", 128'({a, b}), 128'(2'b11));
    apply_stimulus(0, 0, 0, 0, 1, a, b);
    check_output("chain_next_beat", 128'(b), 128'(1));
    drain();
    check_stats();

    // Reset during the second beat of [0,99]
    accept_range(32'd0, 32'd99);
    apply_stimulus(0, 0, 0, 0, 1, a, b);
    check_output("mid_first_beat", 128'(b), 128'(1));
    apply_stimulus(1, 0, 0, 0, 0, a, b);
    check_output("mid_second_beat_shown", 128'(out_valid), 128'(1));
    sb.delete();
    exp_ranges = '0;
    exp_values = '0;
    apply_stimulus(1, 0, 0, 0, 1, a, b);
    check_output("mid_reset_valid", 128'(out_valid), 128'(0));
    check_output("mid_reset_in_ready", 128'(in_ready), 128'(0));
    apply_stimulus(0, 0, 0, 0, 1, a, b);
    check_output("mid_release_in_ready", 128'(in_ready), 128'(1));
    for (int n = 0; n < 4; n++) begin
      apply_stimulus(0, 0, 0, 0, 1, a, b);
      check_output("mid_no_beats", 128'(out_valid), 128'(0));
    end
    check_stats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_expander.md
# range_expander

Range-to-lane expander feeding the keep-masked multi-lane input of the filtered FIFO stage. Accepts inclusive integer ranges `[lo, hi]` one per handshake. Emits each range as successive beats of `LANES` consecutive candidate values with a per-lane keep mask. A downstream predicate can AND its own mask into `out_keep` before the FIFO compacts the beats.

## Interface
- `BIT_WIDTH`, 32, width of one value
- `LANES`, 4, values per output beat; must be >0 and even
- `DATA_TYPE`, `logic [BIT_WIDTH-1:0]`, value type; `$bits` must equal `BIT_WIDTH`
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `in_valid`  in  1  range offered
- `in_lo`  in  `DATA_TYPE`  first value, inclusive
- `in_hi`  in  `DATA_TYPE`  last value, inclusive
- `in_ready`  out  1  range accepted when `in_valid && in_ready`
- `out_valid`  out  1  beat valid
- `out_data`  out  `DATA_TYPE[0:LANES-1]`  lane `i` = `cur + i`
- `out_keep`  out  `LANES`  lane `i` holds an in-range value
- `out_ready`  in  1  beat consumed when `out_valid && out_ready`
- `busy`  out  1  range in progress
- `stat_ranges`  out  32  non-empty ranges accepted; present only with `RANGE_EXPANDER_STATS_EN`
- `stat_values`  out  64  kept values emitted; present only with `RANGE_EXPANDER_STATS_EN`

## Operation
- Two states:
  - IDLE: `in_ready=1`, `out_valid=0`.
  - EMIT: `out_valid=1`.
- Registers: `cur` (BIT_WIDTH), `hi_r` (BIT_WIDTH), `state`.
- Accept with `in_lo <= in_hi` (unsigned): `cur<=in_lo`, `hi_r<=in_hi`, go to EMIT.
- Accept with `in_lo > in_hi`: empty range. It is consumed, no beat is produced, and the state stays IDLE.
- Lane value: `out_data[i] = cur + i`, truncated to BIT_WIDTH.
- Lane keep: `out_keep[i] = (i <= hi_r - cur)`. The difference is computed at BIT_WIDTH, which is safe because `hi_r >= cur`. Lanes past `2^BIT_WIDTH-1` are therefore never kept.
- `last = (hi_r - cur) < LANES`.
- On a beat transfer:
  - If `last`, go to IDLE.
  - Otherwise `cur <= cur + LANES`.
- Zero-bubble chaining: `in_ready = IDLE || (EMIT && last && out_ready)`.
  - A range accepted in the same cycle as the final beat loads `cur`/`hi_r` and stays in EMIT (or goes to IDLE if the new range is empty).
- `out_data` and `out_keep` are 0 whenever `out_valid=0`.
- `busy = (state == EMIT)`.

## Timing
- Reset:
  - state IDLE; `out_valid=0`, `out_keep=0`, `out_data` all 0, `busy=0`.
  - `in_ready=0` while `rst` is high, 1 in the first cycle after `rst` falls.
  - Stats are cleared to 0.
- Latency: range accepted at edge N gives first beat valid in cycle N+1.
- Throughput: one beat per cycle with `out_ready=1`, including across range boundaries.
- Beats needed per range: `ceil((hi-lo+1)/LANES)`. A full-span range (`lo=0`, `hi=max`) terminates correctly.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_keep` are held stable and `in_ready` is low (unless in IDLE).
- `in_valid` may drop without acceptance; inputs are ignored when not accepted.
- Reset mid-range abandons the range. No further beats appear, and stats from before the reset are cleared.

## Configuration
- `RANGE_EXPANDER_STATS_EN` defined:
  - `stat_ranges` increments on each accepted non-empty range.
  - `stat_values` adds `popcount(out_keep)` on each beat transfer.
  - Both wrap modulo their width.
- Not defined: both ports and their counters are absent, and there is no other behavioural difference.

## Test plan
- `LANES=4`, range `[10,15]`, `out_ready=1`:
  - beat {10,11,12,13} keep 1111;
  - then {14,15,16,17} keep 0011;
  - then `out_valid=0`;
  - stats (if enabled) `stat_ranges=1`, `stat_values=6`.
- Ranges `[7,7]` then `[9,8]`:
  - one beat {7,8,9,10} keep 0001;
  - the empty range is accepted with no beat;
  - `stat_ranges` ends at 1.
- Wrap case: `BIT_WIDTH=32`, range `[0xFFFFFFFE, 0xFFFFFFFF]`:
  - single beat, lanes 0 and 1 = 0xFFFFFFFE and 0xFFFFFFFF;
  - keep 0011;
  - no second beat.
- Backpressure: range `[0,11]` with `out_ready` low for 3 cycles during beat {4..7}:
  - the beat is held unchanged;
  - 3 beats total;
  - `in_ready` stays 0 throughout.
- Chaining: ranges `[0,3]` and `[4,7]` presented back-to-back with `out_ready=1`:
  - beats {0..3} and {4..7} in consecutive cycles;
  - the second range is accepted in the cycle of the first's final beat.
- Reset mid-range: assert `rst` during beat 2 of `[0,99]`:
  - `out_valid=0` from the next cycle;
  - no further beats;
  - `in_ready=1` the cycle after `rst` deasserts.
